// File: rtl/ordered_front_end_pkg.sv
// ordered_front_end_pkg: shared request/ROB types for the ordered front end.
`default_nettype none

package ordered_front_end_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 27;

  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type_e;

  typedef struct packed {
    r_type_e                 req_type;
    logic [DEF_ADDR_W-1:0]   address;
    logic [DEF_DATA_W-1:0]   data;
  } request_t;

  typedef struct packed {
    logic                    valid;
    r_type_e                 rtype;
    logic                    done;
    logic [DEF_DATA_W-1:0]   rdata;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/ordered_front_end_rob.sv
// ordered_front_end_rob: reorder buffer storage, completion capture and in-order retire.
`default_nettype none

module ordered_front_end_rob
  import ordered_front_end_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic              acc_type_i,
  input  logic              done_valid_i,
  input  logic              done_type_i,
  input  logic [IDX_W-1:0]  done_index_i,
  input  logic [DATA_W-1:0] done_data_i,
  output logic [IDX_W-1:0]  tail_o,
  output logic              full_o,
  output logic              drop_o,
  output logic              read_done_o,
  output logic              write_done_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  type_q;
  logic [DEPTH-1:0]  done_q;
  logic [DATA_W-1:0] rdata_q [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              read_done_q, read_done_d;
  logic              write_done_q, write_done_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;

  logic w_complete_ok;
  logic w_retire;
  logic w_head_is_read;

  assign w_complete_ok = done_valid_i && valid_q[done_index_i] && !done_q[done_index_i]
                         && (type_q[done_index_i] == done_type_i);
  // Retire looks only at registered done state, so a completion retires no earlier than next cycle.
  assign w_retire       = valid_q[head_q] && done_q[head_q];
  assign w_head_is_read = (type_q[head_q] == R_READ);

  assign tail_o       = tail_q;
  assign full_o       = (count_q == (IDX_W+1)'(DEPTH));
  assign drop_o       = done_valid_i && !w_complete_ok;
  assign read_done_o  = read_done_q;
  assign write_done_o = write_done_q;
  assign rdata_o      = rdata_out_q;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    read_done_d  = w_retire && w_head_is_read;
    write_done_d = w_retire && !w_head_is_read;
    rdata_out_d  = (w_retire && w_head_is_read) ? rdata_q[head_q] : '0;
    if (w_retire) head_d = head_q + 1'b1;
    if (acc_i)    tail_d = tail_q + 1'b1;
    case ({acc_i, w_retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      rdata_out_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
      rdata_out_q  <= rdata_out_d;
    end
  end

  // The accepted slot is always free and the retiring slot is already done, so the
  // three updates below never target the same field of the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      type_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= '0;
    end else begin
      if (w_complete_ok) begin
        done_q[done_index_i] <= 1'b1;
        if (done_type_i == R_READ) rdata_q[done_index_i] <= done_data_i;
      end
      if (w_retire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (acc_i) begin
        valid_q[tail_q] <= 1'b1;
        type_q[tail_q]  <= acc_type_i;
        done_q[tail_q]  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ordered_front_end.sv
// ordered_front_end: request accept, issue register and handshake around the reorder buffer.
// Optional build macro FE_DONE_CHECK_EN adds the sticky err_done output.
`default_nettype none

module ordered_front_end
  import ordered_front_end_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 27,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_type,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_type,
  output logic [IDX_W-1:0]  out_index,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              done_valid,
  input  logic              done_type,
  input  logic [IDX_W-1:0]  done_index,
  input  logic [DATA_W-1:0] done_data,
  output logic              read_done,
  output logic              write_done,
  output logic [DATA_W-1:0] rdata_out
`ifdef FE_DONE_CHECK_EN
  ,
  output logic              err_done
`endif
);

  logic              out_valid_q, out_valid_d;
  logic              out_type_q, out_type_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic             w_full;
  logic             w_drop;
  logic             w_accept;
  logic [IDX_W-1:0] w_tail;

  // Accept only when the issue register is empty or being drained this cycle.
  assign in_ready = !rst && !w_full && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_type_d  = out_type_q;
    out_index_d = out_index_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_type_d  = in_type;
      out_index_d = w_tail;
      out_addr_d  = in_addr;
      out_data_d  = in_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_type_q  <= R_READ;
      out_index_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_type_q  <= out_type_d;
      out_index_q <= out_index_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_type  = out_type_q;
  assign out_index = out_index_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  ordered_front_end_rob #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_rob (
    .clk          (clk),
    .rst          (rst),
    .acc_i        (w_accept),
    .acc_type_i   (in_type),
    .done_valid_i (done_valid),
    .done_type_i  (done_type),
    .done_index_i (done_index),
    .done_data_i  (done_data),
    .tail_o       (w_tail),
    .full_o       (w_full),
    .drop_o       (w_drop),
    .read_done_o  (read_done),
    .write_done_o (write_done),
    .rdata_o      (rdata_out)
  );

`ifdef FE_DONE_CHECK_EN
  logic [IDX_W:0] stall_cnt_q, stall_cnt_d;
  logic           err_q, err_d;

  // Watchdog fires on the (DEPTH+1)-th consecutive cycle of in_valid against a full buffer.
  always_comb begin
    stall_cnt_d = '0;
    if (in_valid && w_full) begin
      stall_cnt_d = stall_cnt_q;
      if (stall_cnt_q != (IDX_W+1)'(DEPTH)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
    err_d = err_q || w_drop
            || (in_valid && w_full && (stall_cnt_q == (IDX_W+1)'(DEPTH)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign err_done = err_q;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ordered_front_end.sv
// tb_ordered_front_end: scoreboard bench for issue order and in-order retire.
`default_nettype none

module tb_ordered_front_end;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 27;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_type = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_type;
  logic [IDX_W-1:0]  out_index;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              done_valid = 1'b0;
  logic              done_type = 1'b0;
  logic [IDX_W-1:0]  done_index = '0;
  logic [DATA_W-1:0] done_data = '0;
  logic              read_done;
  logic              write_done;
  logic [DATA_W-1:0] rdata_out;
`ifdef FE_DONE_CHECK_EN
  logic              err_done;
`endif

  ordered_front_end #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_type   (out_type),
    .out_index  (out_index),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .done_valid (done_valid),
    .done_type  (done_type),
    .done_index (done_index),
    .done_data  (done_data),
    .read_done  (read_done),
    .write_done (write_done),
    .rdata_out  (rdata_out)
`ifdef FE_DONE_CHECK_EN
    ,
    .err_done   (err_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } iss_t;

  iss_t        iss_q[$];
  int          ret_q[$];
  logic        valid_m [DEPTH];
  logic        typ_m   [DEPTH];
  logic        done_m  [DEPTH];
  logic [31:0] data_m  [DEPTH];
  int          tail_m = 0;
  int          n_acc  = 0;
  int          n_ret  = 0;
  int          ret_cyc [1024];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model and scoreboard, evaluated mid-cycle when inputs and outputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        iss_q.delete();
        ret_q.delete();
        tail_m = 0;
        for (int i = 0; i < DEPTH; i++) begin
          valid_m[i] = 1'b0; done_m[i] = 1'b0; typ_m[i] = 1'b0; data_m[i] = '0;
        end
      end else begin
        if (out_valid && out_ready) begin
          if (iss_q.size() == 0) check("issue_unexpected", 64'd1, 64'd0);
          else begin
            iss_t e;
            e = iss_q.pop_front();
            check("out_index", 64'(out_index), 64'(e.idx));
            check("out_type",  64'(out_type),  64'(e.typ));
            check("out_addr",  64'(out_addr),  64'(e.addr));
            check("out_data",  64'(out_data),  64'(e.data));
          end
        end
        if (read_done || write_done) begin
          ret_cyc[n_ret % 1024] = cyc;
          n_ret++;
          check("single_pulse", 64'(read_done && write_done), 64'd0);
          if (ret_q.size() == 0) check("retire_unexpected", 64'd1, 64'd0);
          else begin
            int k;
            k = ret_q.pop_front();
            check("retire_type", 64'(write_done), 64'(typ_m[k]));
            check("retire_was_done", 64'(done_m[k]), 64'd1);
            if (read_done) check("rdata_out", 64'(rdata_out), 64'(data_m[k]));
            valid_m[k] = 1'b0;
            done_m[k]  = 1'b0;
          end
        end
        if (done_valid && valid_m[done_index] && !done_m[done_index]
            && typ_m[done_index] == done_type) begin
          done_m[done_index] = 1'b1;
          data_m[done_index] = done_data;
        end
        if (in_valid && in_ready) begin
          iss_q.push_back('{IDX_W'(tail_m), in_type, in_addr, in_data});
          ret_q.push_back(tail_m);
          valid_m[tail_m] = 1'b1;
          typ_m[tail_m]   = in_type;
          done_m[tail_m]  = 1'b0;
          tail_m = (tail_m + 1) % DEPTH;
          n_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic t, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_type = t; in_addr = a; in_data = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic complete(input logic t, input int idx, input logic [DATA_W-1:0] d);
    done_valid = 1'b1; done_type = t; done_index = IDX_W'(idx); done_data = d;
    tick();
    done_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int c0;

  initial begin
    #2;
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_read_done",  64'(read_done),  64'd0);
    check("rst_write_done", 64'(write_done), 64'd0);
    check("rst_out_index",  64'(out_index),  64'd0);
    check("rst_rdata_out",  64'(rdata_out),  64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: fill with 64 reads; a 65th request must stall
    for (int i = 0; i < DEPTH; i++) send(1'b0, '0, 32'd10);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_full_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t1_all_issued", 64'(iss_q.size()), 64'd0);
    check("t1_accepts", 64'(n_acc), 64'd64);

    // 2: complete youngest first; nothing retires until slot 0 completes
    for (int i = DEPTH - 1; i >= 1; i--) complete(1'b0, i, 32'(i + 100));
    repeat (3) tick();
    check("t2_no_early_retire", 64'(n_ret), 64'd0);
    base = n_ret;
    complete(1'b0, 0, 32'd100);
    repeat (70) tick();
    check("t2_retire_count", 64'(n_ret - base), 64'd64);
    check("t2_back_to_back", 64'(ret_cyc[base + 63] - ret_cyc[base]), 64'd63);

    // 3: R,W,R,W in slots 0..3 completed 3,1,2,0
    for (int i = 0; i < 4; i++) send(1'(i % 2), ADDR_W'(32'h100 + i), 32'hA0 + i);
    repeat (2) tick();
    base = n_ret;
    complete(1'b1, 3, 32'h0);
    complete(1'b1, 1, 32'h0);
    complete(1'b0, 2, 32'h55);
    c0 = cyc;
    complete(1'b0, 0, 32'h77);
    repeat (8) tick();
    check("t3_retire_count", 64'(n_ret - base), 64'd4);
    check("t3_first_retire_cycle", 64'(ret_cyc[base]), 64'(c0 + 2));
    check("t3_last_retire_cycle", 64'(ret_cyc[base + 3]), 64'(c0 + 5));

    // 4: fill to full, stall the scheduler, then free one slot
    for (int i = 0; i < DEPTH; i++) send(1'b1, ADDR_W'(i), 32'(i * 3));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_index", 64'(out_index), 64'd3);
      check("t4_in_ready_low", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_type = 1'b0; in_addr = ADDR_W'(7); in_data = '0;
    base = n_acc;
    complete(1'b1, 4, 32'h0);
    repeat (6) tick();
    in_valid = 1'b0;
    check("t4_one_accept", 64'(n_acc - base), 64'd1);
    tick();

    // 5: reset with 10 outstanding
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) send(1'b1, ADDR_W'(32'h200 + i), 32'hBEEF);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_out_index", 64'(out_index), 64'd0);
    check("t5_rst_out_addr",  64'(out_addr),  64'd0);
    check("t5_rst_out_data",  64'(out_data),  64'd0);
    check("t5_rst_out_type",  64'(out_type),  64'd0);
    check("t5_rst_in_ready",  64'(in_ready),  64'd0);
    check("t5_rst_pulses",    64'({read_done, write_done}), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    send(1'b0, ADDR_W'(32'h3F), 32'h1);
    tick();
    check("t5_first_index_zero_issued", 64'(iss_q.size()), 64'd0);
    base = n_ret;
    complete(1'b0, 5, 32'hDEAD);
    repeat (5) tick();
    check("t5_stale_done_no_retire", 64'(n_ret - base), 64'd0);
    complete(1'b0, 0, 32'h42);
    repeat (4) tick();
    check("t5_slot0_retired", 64'(n_ret - base), 64'd1);

`ifdef FE_DONE_CHECK_EN
    // 6: type-mismatched completion is dropped and flagged
    send(1'b0, ADDR_W'(32'h10), 32'h0);
    tick();
    check("t6_err_clear", 64'(err_done), 64'd0);
    base = n_ret;
    complete(1'b1, 1, 32'h0);
    check("t6_err_set", 64'(err_done), 64'd1);
    repeat (3) tick();
    check("t6_no_retire", 64'(n_ret - base), 64'd0);
    complete(1'b0, 1, 32'h99);
    repeat (4) tick();
    check("t6_retire_after_good_done", 64'(n_ret - base), 64'd1);
    check("t6_err_sticky", 64'(err_done), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
